// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing the register bank write port among four requesters.
// Optional macro REG_WRITE_ARBITER_R0_DISCARD_EN: register 0 is hardwired zero.
module reg_write_arbiter (
  input  logic         CLK,
  input  logic         RST,
  input  logic [3:0]   REQ,
  input  logic [19:0]  REQ_ADDR,
  input  logic [127:0] REQ_DATA,
  output logic [3:0]   GNT,
  output logic [31:0]  LOAD,
  output logic [31:0]  WDATA,
  output logic         BUSY
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  win_q, win_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [31:0] load_q, load_d;
  logic [31:0] wdata_q, wdata_d;
  logic        busy_q, busy_d;

  logic        found_s;
  logic [1:0]  cand_s;
  logic [1:0]  idx_s;
  logic [4:0]  addr_s;
  logic [31:0] data_s;

  // Winner search: first requesting index starting at the priority pointer.
  always_comb begin
    found_s = 1'b0;
    cand_s  = ptr_q;
    idx_s   = ptr_q;
    for (int k = 0; k < 4; k++) begin
      idx_s = ptr_q + 2'(k);
      if (!found_s && REQ[idx_s]) begin
        found_s = 1'b1;
        cand_s  = idx_s;
      end else begin
        cand_s  = cand_s;
      end
    end
  end

  // Select the candidate's address and data.
  always_comb begin
    addr_s = 5'd0;
    data_s = 32'd0;
    case (cand_s)
      2'd0:    begin addr_s = REQ_ADDR[4:0];   data_s = REQ_DATA[31:0];   end
      2'd1:    begin addr_s = REQ_ADDR[9:5];   data_s = REQ_DATA[63:32];  end
      2'd2:    begin addr_s = REQ_ADDR[14:10]; data_s = REQ_DATA[95:64];  end
      2'd3:    begin addr_s = REQ_ADDR[19:15]; data_s = REQ_DATA[127:96]; end
      default: begin addr_s = 5'd0;            data_s = 32'd0;            end
    endcase
  end

  // Next-state and next-output logic; outputs are loaded on the edge entering WRITE.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    gnt_d   = 4'd0;
    load_d  = 32'd0;
    wdata_d = 32'd0;
    busy_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          state_d = S_WRITE;
          win_d   = cand_s;
          gnt_d   = 4'b0001 << cand_s;
          busy_d  = 1'b1;
`ifdef REG_WRITE_ARBITER_R0_DISCARD_EN
          if (addr_s == 5'd0) begin
            load_d  = 32'd0;
            wdata_d = 32'd0;
          end else begin
            load_d  = 32'd1 << addr_s;
            wdata_d = data_s;
          end
`else
          load_d  = 32'd1 << addr_s;
          wdata_d = data_s;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        // The write slot always lasts exactly one cycle.
        state_d = S_IDLE;
        ptr_d   = win_q + 2'd1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, pointer and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      ptr_q   <= 2'd0;
      win_q   <= 2'd0;
      gnt_q   <= 4'd0;
      load_q  <= 32'd0;
      wdata_q <= 32'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      load_q  <= load_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

  assign GNT   = gnt_q;
  assign LOAD  = load_q;
  assign WDATA = wdata_q;
  assign BUSY  = busy_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed vector table, a priority
// rotation sequence, then random traffic against a slot-level reference model.
module tb_reg_write_arbiter;

`ifdef REG_WRITE_ARBITER_R0_DISCARD_EN
  localparam bit R0 = 1'b1;
`else
  localparam bit R0 = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [3:0]   REQ = 4'd0;
  logic [19:0]  REQ_ADDR = 20'd0;
  logic [127:0] REQ_DATA = 128'd0;
  logic [3:0]   GNT;
  logic [31:0]  LOAD;
  logic [31:0]  WDATA;
  logic         BUSY;

  reg_write_arbiter dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
    .GNT(GNT), .LOAD(LOAD), .WDATA(WDATA), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: pointer, pending slot and winner as plain integers.
  int          m_p = 0;
  int          m_w = 0;
  bit          m_busy = 1'b0;
  logic [3:0]  e_gnt;
  logic [31:0] e_load, e_wdata;
  logic        e_busy;

  typedef struct {
    bit           rst;
    logic [3:0]   req;
    logic [19:0]  addr;
    logic [127:0] data;
    logic [3:0]   gnt;
    logic [31:0]  load;
    logic [31:0]  wdata;
    bit           busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, logic [3:0] q, logic [19:0] a, logic [127:0] d,
                              logic [3:0] g, logic [31:0] l, logic [31:0] w, bit b);
    vec_t v;
    v.rst = r; v.req = q; v.addr = a; v.data = d;
    v.gnt = g; v.load = l; v.wdata = w; v.busy = b;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Predict the outputs after the coming edge from the current inputs.
  task automatic model_step();
    int a;
    e_gnt = 4'd0; e_load = 32'd0; e_wdata = 32'd0; e_busy = 1'b0;
    if (RST) begin
      m_p = 0; m_busy = 1'b0;
    end else if (m_busy) begin
      m_p = (m_w + 1) % 4;
      m_busy = 1'b0;
    end else if (REQ != 4'd0) begin
      for (int k = 0; k < 4; k++) begin
        if (REQ[(m_p + k) % 4]) begin
          m_w = (m_p + k) % 4;
          break;
        end
      end
      a = int'(REQ_ADDR[5*m_w +: 5]);
      e_gnt = 4'b0001 << m_w;
      e_busy = 1'b1;
      if (!(R0 && a == 0)) begin
        e_load = 32'd1 << a;
        e_wdata = REQ_DATA[32*m_w +: 32];
      end
      m_busy = 1'b1;
    end
  endtask

  task automatic tick_check(input string tag);
    model_step();
    @(posedge CLK);
    #1;
    chk({tag, ".gnt"}, 32'(GNT), 32'(e_gnt));
    chk({tag, ".load"}, LOAD, e_load);
    chk({tag, ".wdata"}, WDATA, e_wdata);
    chk({tag, ".busy"}, 32'(BUSY), 32'(e_busy));
  endtask

  localparam logic [19:0]  A_RR = {5'd4, 5'd3, 5'd2, 5'd1};
  localparam logic [127:0] D_RR = {32'h103, 32'h102, 32'h101, 32'h100};
  localparam logic [31:0]  R0_LOAD = R0 ? 32'd0 : 32'd1;
  localparam logic [31:0]  R0_WD   = R0 ? 32'd0 : 32'd13;

  logic [3:0] rot_exp[9];

  initial begin
    // Reset held two edges with all requesting, then round-robin over all four.
    tbl.push_back(mk(1'b1, 4'b1111, A_RR, D_RR, 4'd0, 32'd0, 32'd0, 1'b0));
    tbl.push_back(mk(1'b1, 4'b1111, A_RR, D_RR, 4'd0, 32'd0, 32'd0, 1'b0));
    tbl.push_back(mk(1'b0, 4'b1111, A_RR, D_RR, 4'b0001, 32'h2,  32'h100, 1'b1));
    tbl.push_back(mk(1'b0, 4'b1111, A_RR, D_RR, 4'd0, 32'd0, 32'd0, 1'b0));
    tbl.push_back(mk(1'b0, 4'b1111, A_RR, D_RR, 4'b0010, 32'h4,  32'h101, 1'b1));
    tbl.push_back(mk(1'b0, 4'b1111, A_RR, D_RR, 4'd0, 32'd0, 32'd0, 1'b0));
    tbl.push_back(mk(1'b0, 4'b1111, A_RR, D_RR, 4'b0100, 32'h8,  32'h102, 1'b1));
    tbl.push_back(mk(1'b0, 4'b1111, A_RR, D_RR, 4'd0, 32'd0, 32'd0, 1'b0));
    tbl.push_back(mk(1'b0, 4'b1111, A_RR, D_RR, 4'b1000, 32'h10, 32'h103, 1'b1));
    tbl.push_back(mk(1'b0, 4'b1111, A_RR, D_RR, 4'd0, 32'd0, 32'd0, 1'b0));
    tbl.push_back(mk(1'b0, 4'b1111, A_RR, D_RR, 4'b0001, 32'h2,  32'h100, 1'b1));
    tbl.push_back(mk(1'b0, 4'b0000, 20'd0, 128'd0, 4'd0, 32'd0, 32'd0, 1'b0));
    // Single write: requester 2, address 9, data 24.
    tbl.push_back(mk(1'b0, 4'b0100, {5'd0, 5'd9, 5'd0, 5'd0}, {32'd0, 32'd24, 32'd0, 32'd0},
                     4'b0100, 32'h0000_0200, 32'd24, 1'b1));
    tbl.push_back(mk(1'b0, 4'b0000, 20'd0, 128'd0, 4'd0, 32'd0, 32'd0, 1'b0));
    // Address 0 write from requester 1.
    tbl.push_back(mk(1'b0, 4'b0010, 20'd0, {32'd0, 32'd0, 32'd13, 32'd0},
                     4'b0010, R0_LOAD, R0_WD, 1'b1));
    tbl.push_back(mk(1'b0, 4'b0000, 20'd0, 128'd0, 4'd0, 32'd0, 32'd0, 1'b0));
    tbl.push_back(mk(1'b0, 4'b0000, 20'd0, 128'd0, 4'd0, 32'd0, 32'd0, 1'b0));
    // Reset on the edge that ends a WRITE slot, then P must be back at 0.
    tbl.push_back(mk(1'b0, 4'b1000, {5'd5, 5'd0, 5'd0, 5'd0}, {32'd55, 96'd0},
                     4'b1000, 32'h20, 32'd55, 1'b1));
    tbl.push_back(mk(1'b1, 4'b1000, {5'd5, 5'd0, 5'd0, 5'd0}, {32'd55, 96'd0},
                     4'd0, 32'd0, 32'd0, 1'b0));
    tbl.push_back(mk(1'b0, 4'b0110, {5'd0, 5'd8, 5'd7, 5'd0}, {32'd0, 32'd88, 32'd77, 32'd0},
                     4'b0010, 32'h80, 32'd77, 1'b1));
    tbl.push_back(mk(1'b0, 4'b0000, 20'd0, 128'd0, 4'd0, 32'd0, 32'd0, 1'b0));

    @(negedge CLK);
    foreach (tbl[i]) begin
      RST = tbl[i].rst; REQ = tbl[i].req; REQ_ADDR = tbl[i].addr; REQ_DATA = tbl[i].data;
      tick_check("model");
      chk($sformatf("vec%0d.gnt", i), 32'(GNT), 32'(tbl[i].gnt));
      chk($sformatf("vec%0d.load", i), LOAD, tbl[i].load);
      chk($sformatf("vec%0d.wdata", i), WDATA, tbl[i].wdata);
      chk($sformatf("vec%0d.busy", i), 32'(BUSY), 32'(tbl[i].busy));
    end

    // Priority rotation: 0,1,0,1 with REQ=0011, then adding req 3 wins over 0.
    rot_exp = '{4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000};
    RST = 1'b1; REQ = 4'b0011; REQ_ADDR = A_RR; REQ_DATA = D_RR;
    for (int i = 0; i < 9; i++) begin
      tick_check("rot_model");
      chk($sformatf("rot%0d.gnt", i), 32'(GNT), 32'(rot_exp[i]));
      RST = 1'b0;
    end
    REQ = 4'b1011;
    tick_check("rot_model");
    chk("rot_req3.gnt", 32'(GNT), 32'(4'b1000));

    // Random traffic, occasional resets.
    for (int i = 0; i < 400; i++) begin
      RST = ($urandom_range(0, 49) == 0);
      REQ = 4'($urandom_range(0, 15));
      REQ_ADDR = 20'($urandom);
      REQ_DATA = {$urandom, $urandom, $urandom, $urandom};
      tick_check("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
